// File: rtl/dmem_bytelane.sv
// Byte-addressed data memory with a valid/ready request port and a registered response port.
// Handles byte-lane stores, sign/zero-extended loads, and flags misaligned or illegal accesses.
module dmem_bytelane #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);
  localparam int unsigned IDX_W = ADDR_W - OFF_W;
  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam bit          WIDE  = (DATA_W == 64);

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        size;
  logic              zext;
  logic              legal;
  logic              misaligned;
  logic              err;
  logic              accept;
  logic              wr_en;
  logic [NB-1:0]     be;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] load_data;
  logic              sign;

  logic              rsp_valid_d, rsp_valid_q;
  logic              rsp_err_d, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_d, rsp_rdata_q;

  logic [DATA_W-1:0] mem [DEPTH];

  assign off = req_addr[OFF_W-1:0];
  assign idx = req_addr[ADDR_W-1:OFF_W];

  // Holding reset keeps the port closed, so a store on a reset edge never lands.
  assign req_ready = rst_n && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    size = 4'd1;
    unique case (req_funct3[1:0])
      2'b00:   size = 4'd1;
      2'b01:   size = 4'd2;
      2'b10:   size = 4'd4;
      default: size = 4'd8;
    endcase
    zext = req_funct3[2];
  end

  always_comb begin
    legal = 1'b0;
    if (req_we) begin
      legal = (req_funct3 inside {3'b000, 3'b001, 3'b010}) || (WIDE && req_funct3 == 3'b011);
    end else begin
      legal = (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
              (WIDE && (req_funct3 inside {3'b011, 3'b110}));
    end
  end

  assign misaligned = |(off & OFF_W'(size - 4'd1));
  assign err        = !legal || misaligned;
  assign wr_en      = accept && req_we && !err;

  always_comb begin
    be = '0;
    for (int b = 0; b < int'(NB); b++) begin
      be[b] = (b >= int'(off)) && (b < int'(off) + int'(size));
    end
  end

  assign wdata_sh = req_wdata << {off, 3'b000};

  // Storage is deliberately left out of reset; only the response path is cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < int'(NB); b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign rd_word = mem[idx];
  assign rd_sh   = rd_word >> {off, 3'b000};

  // Bytes beyond the access size are filled with the sign bit or zero.
  always_comb begin
    sign = 1'b0;
    for (int b = 0; b < int'(NB); b++) begin
      if (b == int'(size) - 1) sign = rd_sh[8*b + 7];
    end
    load_data = '0;
    for (int b = 0; b < int'(NB); b++) begin
      if (b < int'(size)) load_data[8*b +: 8] = rd_sh[8*b +: 8];
      else                load_data[8*b +: 8] = {8{sign && !zext}};
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err;
      rsp_rdata_d = (err || req_we) ? '0 : load_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/dmem_bytelane.md
# dmem_bytelane

Parametrised, byte-addressed data memory for the RISC-V datapath. It replaces the word-indexed load/store memory with a valid/ready request port and a registered response port. It has true byte-lane stores, so SB/SH modify only their bytes. It also detects misaligned and illegal accesses, and supports 32- or 64-bit data words. It sits between the ALU address/store-data path and the writeback mux.

## Interface
- ADDR_W, 11: byte-address width. Depth is 2**(ADDR_W-OFF_W) words, where OFF_W = log2(DATA_W/8).
- DATA_W, 32: word width. Legal values are 32 or 64.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request can be accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 of the load/store.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  DATA_W  load result, extended to DATA_W. It is 0 for stores and errors.
- rsp_err  out  1  access was misaligned or the funct3 was illegal.

## Operation
- Address split:
  - off = req_addr[OFF_W-1:0]
  - idx = req_addr[ADDR_W-1:OFF_W]
- Access size (bytes) from funct3:
  - 000 or 100: 1
  - 001 or 101: 2
  - 010 or 110: 4
  - 011: 8
- Legal loads:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - With DATA_W=64 only: 011 LD and 110 LWU.
- Legal stores:
  - 000 SB, 001 SH, 010 SW.
  - With DATA_W=64 only: 011 SD.
- Every other funct3/direction combination is illegal.
- An access is misaligned when off is not a multiple of its size.
- Error access (illegal or misaligned):
  - No memory write.
  - The response carries rsp_err=1 and rsp_rdata=0.
- Store:
  - Byte-enable mask = ((1<<size)-1) << off.
  - Store data = req_wdata << (8*off).
  - Only enabled bytes of mem[idx] change; all other bytes keep their values.
- Load:
  - Bytes [off +: size] are taken from mem[idx].
  - Sign-extended for 000/001/010 (when 010 is narrower than DATA_W), zero-extended for 100/101/110.
  - A full-width load returns the word unchanged.
- Stores also produce a response (rsp_rdata=0, rsp_err per checks) so the pipeline gets a completion for every request.
- Memory array is not reset; reset clears only control and response state.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0. req_ready=1 once rst_n is high.
- req_ready = !rsp_valid || rsp_ready (combinational). This allows one outstanding response with full-throughput pass-through.
- Accept = req_valid && req_ready at rising edge T:
  - A store writes memory at T.
  - A load reads mem[idx] as it stood before edge T.
  - rsp_valid=1 with the result is visible after T, so latency is 1 cycle.
- Response hold: while rsp_valid && !rsp_ready, rsp_valid, rsp_rdata and rsp_err hold stable and req_ready=0. No request is accepted and no memory write occurs.
- rsp_valid && rsp_ready && !accept at an edge: rsp_valid falls to 0.
- rsp_valid && rsp_ready && accept at the same edge: the response register is reloaded with the new result; rsp_valid stays 1.
- Store at edge T followed by a load to the same word at T+1: the load returns the stored data. No forwarding is needed because of the single port.
- req_* inputs are ignored while req_valid=0, and while req_ready=0 (no side effects).
- Reset asserted mid-operation:
  - Any pending response is discarded immediately and asynchronously.
  - A store whose edge coincides with rst_n low is not performed.
  - Memory contents from completed stores are preserved.
- Throughput is one access per cycle when rsp_ready is held high.

## Test plan
- Reset: drive rst_n low mid-cycle with rsp_valid=1 -> rsp_valid, rsp_rdata and rsp_err go to 0 immediately. req_ready=1 after release.
- Byte-lane store/load (DATA_W=32):
  - SW 0x11223344 to addr 0x40, then SB 0xAB to 0x41, then SH 0xBEEF to 0x42.
  - LW 0x40 -> 0xBEEFAB44.
  - LB 0x41 -> 0xFFFFFFAB. LBU 0x41 -> 0x000000AB.
  - LH 0x42 -> 0xFFFFBEEF. LHU 0x42 -> 0x0000BEEF.
- Misaligned and illegal accesses:
  - LW 0x42 -> rsp_err=1, rdata=0.
  - SH 0x43 -> rsp_err=1, and a following LW 0x40 is unchanged.
  - funct3=011 with DATA_W=32 -> rsp_err=1.
- Backpressure:
  - Hold rsp_ready=0 for 3 cycles after a load -> response stable, req_ready=0, and a concurrent store request is not written.
  - Raise rsp_ready -> next request accepted the same edge.
- Back-to-back throughput: with rsp_ready=1, alternate SW/LW to 16 consecutive words -> one response per cycle, every load returning the value stored on the previous cycle.
- DATA_W=64 build:
  - SD 0x0123456789ABCDEF to 0x08, then LWU 0x0C -> 0x0000000001234567.
  - LW 0x08 -> 0xFFFFFFFF89ABCDEF.
  - LD 0x08 -> 0x0123456789ABCDEF.
